// File: rtl/data_sequencer.sv
// Two-requester transaction sequencer: arbitrates, latches the winner's payloads and
// drives a fixed SEND_A -> SEND_B -> DONE word sequence toward the data generator.
module data_sequencer #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [17:0] a0,
    input  logic [17:0] a1,
    input  logic [29:0] b0,
    input  logic [29:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] lat_a_q, lat_a_d;
    logic [29:0] lat_b_q, lat_b_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [31:0] data_a_q, data_a_d;
    logic [31:0] data_b_q, data_b_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        busy_q, busy_d;

    logic any_req;
    logic win;

    assign any_req = req0 | req1;

    // On a tie, round-robin favours whoever was not served last.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = FIXED_PRIO ? 1'b0 : ~last_q;
        end else if (req1) begin
            win = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lat_a_q  <= '0;
            lat_b_q  <= '0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            data_a_q <= '0;
            data_b_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_a_q  <= lat_a_d;
            lat_b_q  <= lat_b_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and datapath capture
    always_comb begin
        state_d = state_q;
        lat_a_d = lat_a_q;
        lat_b_d = lat_b_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = SEND_A;
                    lat_a_d = win ? a1 : a0;
                    lat_b_d = win ? b1 : b0;
                    grant_d = win;
                end
            end
            SEND_A: state_d = SEND_B;
            SEND_B: begin
                state_d = DONE;
                last_d  = grant_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        data_a_d = '0;
        data_b_d = '0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        busy_d   = 1'b0;
        case (state_d)
            SEND_A: begin
                data_a_d = {13'd0, 1'b1, lat_a_d};
                busy_d   = 1'b1;
            end
            SEND_B: begin
                data_a_d = {13'd0, 1'b0, lat_a_d};
                data_b_d = {1'b0, 1'b1, lat_b_d};
                busy_d   = 1'b1;
            end
            DONE: begin
                data_a_d = {13'd0, 1'b0, lat_a_d};
                data_b_d = {2'b00, lat_b_d};
                ack0_d   = ~grant_d;
                ack1_d   = grant_d;
                busy_d   = 1'b1;
            end
            default: begin
                data_a_d = '0;
                data_b_d = '0;
            end
        endcase
    end

    assign dataA = data_a_q;
    assign dataB = data_b_q;
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign busy  = busy_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_data_sequencer.sv
// Directed bench for data_sequencer: single request, ties under both arbitration
// modes, payload stability, mid-transaction reset and a simple generator model.
module tb_data_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [17:0] a0, a1;
    logic [29:0] b0, b1;

    logic        ack0, ack1, busy, grant;
    logic [31:0] dataA, dataB;
    logic        ack0_f, ack1_f, busy_f, grant_f;
    logic [31:0] dataA_f, dataB_f;

    logic [31:0] gen_a = '0;
    logic [31:0] gen_b = '0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_sequencer #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .ack0(ack0), .ack1(ack1), .dataA(dataA), .dataB(dataB),
        .busy(busy), .grant(grant)
    );

    data_sequencer #(.FIXED_PRIO(1'b1)) dut_f (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .ack0(ack0_f), .ack1(ack1_f), .dataA(dataA_f), .dataB(dataB_f),
        .busy(busy_f), .grant(grant_f)
    );

    // Minimal data-generator model: captures each word when its valid flag is set.
    always @(posedge clk) begin
        if (dataA[18]) gen_a <= {14'd0, dataA[17:0]};
        if (dataB[30]) gen_b <= dataB;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        step();
        step();
        check("rst_dataA", dataA, 32'h0);
        check("rst_dataB", dataB, 32'h0);
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd0);

        // Single request from requester 0
        reset = 1'b1;
        req0 = 1'b1; a0 = 18'h2A5A5; b0 = 30'h1234_5678;
        step();
        check("single_sa_dataA", dataA, 32'h0006_A5A5);
        check("single_sa_dataB", dataB, 32'h0);
        check("single_sa_busy", {31'd0, busy}, 32'd1);
        check("single_sa_ack0", {31'd0, ack0}, 32'd0);
        check("single_sa_grant", {31'd0, grant}, 32'd0);
        req0 = 1'b0; a0 = 18'h0;
        step();
        check("single_sb_dataA", dataA, 32'h0002_A5A5);
        check("single_sb_dataB", dataB, 32'h5234_5678);
        check("single_sb_ack0", {31'd0, ack0}, 32'd0);
        step();
        check("single_done_ack0", {31'd0, ack0}, 32'd1);
        check("single_done_ack1", {31'd0, ack1}, 32'd0);
        check("single_done_busy", {31'd0, busy}, 32'd1);
        check("single_done_dataA", dataA, 32'h0002_A5A5);
        check("single_done_dataB", dataB, 32'h1234_5678);
        step();
        check("single_idle_ack0", {31'd0, ack0}, 32'd0);
        check("single_idle_busy", {31'd0, busy}, 32'd0);
        check("single_idle_dataA", dataA, 32'h0);
        check("single_idle_dataB", dataB, 32'h0);
        check("gen_a", gen_a, 32'h0002_A5A5);
        check("gen_b", gen_b, 32'h5234_5678);

        // Tie held: round-robin 0,1,0,1 on dut; requester 0 only on dut_f
        reset = 1'b0;
        step();
        reset = 1'b1;
        a0 = 18'h00011; b0 = 30'h0000_0022;
        a1 = 18'h00033; b1 = 30'h0000_0044;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rr%0d_grant", k), {31'd0, grant}, k % 2);
            check($sformatf("rr%0d_dataA", k), dataA, (k % 2) ? 32'h0004_0033 : 32'h0004_0011);
            check($sformatf("fp%0d_grant", k), {31'd0, grant_f}, 32'd0);
            step();
            check($sformatf("rr%0d_dataB", k), dataB, (k % 2) ? 32'h4000_0044 : 32'h4000_0022);
            step();
            check($sformatf("rr%0d_ack0", k), {31'd0, ack0}, (k % 2) ? 32'd0 : 32'd1);
            check($sformatf("rr%0d_ack1", k), {31'd0, ack1}, (k % 2) ? 32'd1 : 32'd0);
            check($sformatf("fp%0d_ack0", k), {31'd0, ack0_f}, 32'd1);
            check($sformatf("fp%0d_ack1", k), {31'd0, ack1_f}, 32'd0);
            step();
            check($sformatf("rr%0d_idle_busy", k), {31'd0, busy}, 32'd0);
            check($sformatf("rr%0d_idle_ack", k), {30'd0, ack1, ack0}, 32'd0);
        end

        // Reset asserted during SEND_B aborts without ack
        req1 = 1'b0;
        step();
        check("mid_sa_grant", {31'd0, grant}, 32'd0);
        step();
        check("mid_sb_dataB", dataB, 32'h4000_0022);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_dataA", dataA, 32'h0);
        check("mid_rst_dataB", dataB, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        step();
        check("mid_rst_ack0", {31'd0, ack0}, 32'd0);
        check("mid_rst_busy2", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        step();
        check("post_sa_dataA", dataA, 32'h0004_0011);
        check("post_sa_busy", {31'd0, busy}, 32'd1);
        step();
        check("post_sb_ack0", {31'd0, ack0}, 32'd0);
        step();
        check("post_done_ack0", {31'd0, ack0}, 32'd1);
        check("post_done_ack1", {31'd0, ack1}, 32'd0);
        req0 = 1'b0;
        step();
        check("post_idle_busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sequencer.md
DATA_SEQUENCER -- requirements
Module: data_sequencer

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin between requesters, 1 = requester 0 always wins ties.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req0/req1, input, 1 each, transaction request from requester 0/1.
REQ-005 The block SHALL have ports a0/a1, input, 18 each, word-A payload from requester 0/1.
REQ-006 The block SHALL have ports b0/b1, input, 30 each, word-B payload from requester 0/1.
REQ-007 The block SHALL have ports ack0/ack1, output, 1 each, one-cycle transaction-complete pulse to requester 0/1.
REQ-008 The block SHALL have port dataA, output, 32, word-A bus to the data generator: [17:0] payload, [18] valid flag, [31:19] zero.
REQ-009 The block SHALL have port dataB, output, 32, word-B bus to the data generator: [29:0] payload, [30] valid flag, [31] zero.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port grant, output, 1, index of the requester currently or last served.

Function
REQ-012 The FSM SHALL have states IDLE, SEND_A, SEND_B, DONE; all outputs registered.
REQ-013 In IDLE with any req high at a rising edge, the block SHALL latch the winner's a/b payloads, set grant, and enter SEND_A.
REQ-014 Arbitration SHALL be: single request wins; both high with FIXED_PRIO=0 -> requester not served last; with FIXED_PRIO=1 -> requester 0.
REQ-015 In SEND_A (exactly 1 cycle), dataA SHALL be {13'd0,1'b1,latched_a}; dataB SHALL be 0; next state SEND_B.
REQ-016 In SEND_B (exactly 1 cycle), dataA SHALL be {13'd0,1'b0,latched_a}; dataB SHALL be {1'b0,1'b1,latched_b}; next state DONE.
REQ-017 In DONE (exactly 1 cycle), dataA[18] and dataB[30] SHALL be 0 with payload fields held; ack[grant] SHALL be 1; next state IDLE.
REQ-018 In IDLE, dataA and dataB SHALL be 0 and both acks 0.
REQ-019 Request-to-ack latency SHALL be 3 cycles after the granting edge; back-to-back transactions SHALL start no sooner than 4 cycles apart (guarantees the generator's clear cycle completes first).
REQ-020 Payload changes after the granting edge SHALL have no effect on the transaction in flight.
REQ-021 req SHALL be sampled only in IDLE; a req still high in the IDLE cycle after its ack SHALL be served as a new transaction.
REQ-022 The round-robin last-served record SHALL update only on entry to DONE.
REQ-023 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-024 While reset is low, the block SHALL be in IDLE with dataA=0, dataB=0, ack0=ack1=0, busy=0, grant=0, latched payloads 0, and last-served=1 (requester 0 wins first tie).
REQ-025 Reset asserted mid-transaction SHALL abort it immediately with no ack; release SHALL resume in IDLE.

Verification
REQ-026 Single request: req0=1, a0=18'h2A5A5, b0=30'h1234_5678 -> SEND_A dataA=32'h0006_A5A5; SEND_B dataB=32'h5234_5678; ack0 pulse 3 cycles after grant; busy high 3 cycles.
REQ-027 Tie, round-robin: req0=req1=1 held after reset -> service order 0,1,0,1; each start 4 cycles apart; grant toggles.
REQ-028 Tie with FIXED_PRIO=1: req0=req1=1 held -> only requester 0 served; ack1 never asserted.
REQ-029 Payload stability: change a0 to 18'h0 one cycle after grant -> dataA payload remains 18'h2A5A5 through DONE.
REQ-030 Reset mid-operation: assert reset during SEND_B -> dataA=dataB=0, busy=0 asynchronously; no ack; after release with req0 high, a full new transaction with ack0.
REQ-031 Integration with the data generator: drive its dataA/dataB from this block -> generator output pair equals {14'd0,a0} and {2'b00,b0}... with dataB bit 30 set, i.e. 32'h0002_A5A5 and 32'h5234_5678 after the DONE cycle.
